// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit: shift scoreboard of in-flight writers
// producing registered EX bypass selects and a combinational load-use stall.
module fwd_scoreboard #(
    parameter int NUM_SRC  = 2,
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2,
    parameter int CNTW     = 16,
    localparam int SELW    = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_we,
    input  logic                      id_is_load,
    input  logic                      hold,
    input  logic                      flush,
    output logic                      stall,
    output logic [NUM_SRC*SELW-1:0]   fwd_sel,
    output logic [CNTW-1:0]           stall_cnt
);

    // The oldest slot (DEPTH-1) is never searched because regfile
    // write-through covers it, so only slots 0..DEPTH-2 are stored.
    localparam int NS = DEPTH - 1;

    logic [NS-1:0]     slot_v;
    logic [NS-1:0]     slot_we;
    logic [NS-1:0]     slot_ld;
    logic [REG_AW-1:0] slot_rd [NS];

    logic [NS-1:0]           writer;
    logic [NUM_SRC-1:0]      hazard;
    logic [NUM_SRC*SELW-1:0] sel_next;

    always_comb begin
        for (int k = 0; k < NS; k++) begin
            writer[k] = slot_v[k] & slot_we[k] & (slot_rd[k] != '0);
        end
    end

    // Oldest slot first so the youngest match overwrites it.
    always_comb begin
        hazard   = '0;
        sel_next = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = NS - 1; k >= 0; k--) begin
                if (id_valid && id_rs_used[i] &&
                    (id_rs[i*REG_AW +: REG_AW] != '0) && writer[k] &&
                    (slot_rd[k] == id_rs[i*REG_AW +: REG_AW])) begin
                    sel_next[i*SELW +: SELW] = SELW'(k + 1);
                    hazard[i] = slot_ld[k] && (LOAD_LAT > k + 1);
                end
            end
        end
    end

    assign stall = (|hazard) & ~hold & ~flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot_v    <= '0;
            slot_we   <= '0;
            slot_ld   <= '0;
            for (int k = 0; k < NS; k++) begin
                slot_rd[k] <= '0;
            end
            fwd_sel   <= '0;
            stall_cnt <= '0;
        end else if (!hold) begin
            for (int k = 1; k < NS; k++) begin
                slot_v[k]  <= flush ? 1'b0 : slot_v[k-1];
                slot_we[k] <= slot_we[k-1];
                slot_ld[k] <= slot_ld[k-1];
                slot_rd[k] <= slot_rd[k-1];
            end
            slot_v[0]  <= (flush || stall) ? 1'b0 : id_valid;
            slot_we[0] <= id_we;
            slot_ld[0] <= id_is_load;
            slot_rd[0] <= id_rd;
            fwd_sel    <= (flush || stall) ? '0 : sel_next;
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed table-driven bench for fwd_scoreboard (default instance plus a
// DEPTH=5 / LOAD_LAT=3 / CNTW=2 instance for latency and saturation).
module tb_fwd_scoreboard;

    typedef struct {
        logic        v;
        logic [4:0]  rs0;
        logic [4:0]  rs1;
        logic [1:0]  used;
        logic [4:0]  rd;
        logic        we;
        logic        ld;
        logic        hold;
        logic        flush;
        logic        exp_stall;
        logic [5:0]  exp_sel;
        logic [15:0] exp_cnt;
    } vec_t;

    logic        clk;
    logic        rstn;

    logic        id_valid, id_we, id_is_load, hold, flush, stall;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [4:0]  id_rd;
    logic [3:0]  fwd_sel;
    logic [15:0] stall_cnt;

    logic        b_valid, b_we, b_is_load, b_hold, b_flush, b_stall;
    logic [9:0]  b_rs;
    logic [1:0]  b_rs_used;
    logic [4:0]  b_rd;
    logic [5:0]  b_fwd_sel;
    logic [1:0]  b_stall_cnt;

    int checks   = 0;
    int failures = 0;

    fwd_scoreboard dut (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rd(id_rd), .id_we(id_we),
        .id_is_load(id_is_load), .hold(hold), .flush(flush),
        .stall(stall), .fwd_sel(fwd_sel), .stall_cnt(stall_cnt)
    );

    fwd_scoreboard #(.DEPTH(5), .LOAD_LAT(3), .CNTW(2)) dut2 (
        .clk(clk), .rstn(rstn), .id_valid(b_valid), .id_rs(b_rs),
        .id_rs_used(b_rs_used), .id_rd(b_rd), .id_we(b_we),
        .id_is_load(b_is_load), .hold(b_hold), .flush(b_flush),
        .stall(b_stall), .fwd_sel(b_fwd_sel), .stall_cnt(b_stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(logic v, logic [4:0] rs0, logic [4:0] rs1,
                                logic [1:0] used, logic [4:0] rd, logic we,
                                logic ld, logic hl, logic fl, logic es,
                                logic [5:0] esel, logic [15:0] ecnt);
        vec_t t;
        t.v = v; t.rs0 = rs0; t.rs1 = rs1; t.used = used; t.rd = rd;
        t.we = we; t.ld = ld; t.hold = hl; t.flush = fl;
        t.exp_stall = es; t.exp_sel = esel; t.exp_cnt = ecnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t, input bit second);
        if (!second) begin
            id_valid = t.v; id_rs = {t.rs1, t.rs0}; id_rs_used = t.used;
            id_rd = t.rd; id_we = t.we; id_is_load = t.ld;
            hold = t.hold; flush = t.flush;
        end else begin
            b_valid = t.v; b_rs = {t.rs1, t.rs0}; b_rs_used = t.used;
            b_rd = t.rd; b_we = t.we; b_is_load = t.ld;
            b_hold = t.hold; b_flush = t.flush;
        end
    endtask

    // Called #1 after a rising edge: drive, sample stall mid-cycle, then
    // sample the registered outputs #1 after the next edge.
    task automatic run_vec(input vec_t t, input bit second, input string tag);
        drive(t, second);
        #3;
        chk({tag, "_stall"}, second ? 32'(b_stall) : 32'(stall), 32'(t.exp_stall));
        @(posedge clk);
        #1;
        chk({tag, "_sel"}, second ? 32'(b_fwd_sel) : 32'(fwd_sel), 32'(t.exp_sel));
        chk({tag, "_cnt"}, second ? 32'(b_stall_cnt) : 32'(stall_cnt), 32'(t.exp_cnt));
    endtask

    vec_t tbl[$];
    vec_t tbl2[$];
    vec_t idle;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //            v rs0 rs1 us rd we ld hl fl | stall sel cnt
        tbl.push_back(mk(0,  0,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // nop
        tbl.push_back(mk(1,  1,  2, 3,  5, 1, 0, 0, 0, 0, 0, 0)); // add x5
        tbl.push_back(mk(1,  5,  5, 3,  6, 1, 0, 0, 0, 0, 5, 0)); // sub x6,x5,x5 -> {1,1}
        tbl.push_back(mk(0,  0,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  1,  2, 3, 10, 1, 0, 0, 0, 0, 0, 0)); // add x10
        tbl.push_back(mk(0,  0,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // nop
        tbl.push_back(mk(1, 10,  0, 3,  7, 1, 0, 0, 0, 0, 2, 0)); // or x7,x10,x0 -> {0,2}
        tbl.push_back(mk(1,  1,  0, 1,  5, 1, 1, 0, 0, 0, 0, 0)); // lw x5
        tbl.push_back(mk(1,  5,  1, 3,  6, 1, 0, 0, 0, 1, 0, 1)); // add x6,x5,x1 stalls
        tbl.push_back(mk(1,  5,  1, 3,  6, 1, 0, 0, 0, 0, 2, 1)); // then sel 2
        tbl.push_back(mk(1,  1,  2, 3,  5, 1, 0, 0, 0, 0, 0, 1)); // add x5
        tbl.push_back(mk(1,  1,  2, 3,  5, 1, 0, 0, 0, 0, 0, 1)); // add x5
        tbl.push_back(mk(1,  5,  5, 3,  8, 1, 0, 0, 0, 0, 5, 1)); // youngest wins {1,1}
        tbl.push_back(mk(1,  1,  2, 3,  0, 1, 1, 0, 0, 0, 0, 1)); // lw x0
        tbl.push_back(mk(1,  0,  0, 3,  9, 1, 0, 0, 0, 0, 0, 1)); // use x0
        tbl.push_back(mk(1,  1,  2, 3, 11, 0, 0, 0, 0, 0, 0, 1)); // we=0 on x11
        tbl.push_back(mk(1, 11,  9, 3, 12, 1, 0, 0, 0, 0, 8, 1)); // x11 none, x9 -> 2
        tbl.push_back(mk(1, 12,  0, 0, 13, 1, 0, 0, 0, 0, 0, 1)); // operands unused
        tbl.push_back(mk(1, 13, 12, 3, 14, 1, 0, 0, 0, 0, 9, 1)); // {2,1}
        tbl.push_back(mk(1, 14,  0, 3, 16, 1, 0, 1, 0, 0, 9, 1)); // hold x3
        tbl.push_back(mk(1, 14,  0, 3, 16, 1, 0, 1, 0, 0, 9, 1));
        tbl.push_back(mk(1, 14,  0, 3, 16, 1, 0, 1, 0, 0, 9, 1));
        tbl.push_back(mk(1, 14,  0, 3, 16, 1, 0, 0, 0, 0, 1, 1)); // released
        tbl.push_back(mk(1,  1,  2, 3, 17, 1, 1, 0, 0, 0, 0, 1)); // lw x17
        tbl.push_back(mk(1, 17, 16, 3, 18, 1, 0, 1, 0, 0, 0, 1)); // hazard under hold
        tbl.push_back(mk(1, 17, 16, 3, 18, 1, 0, 0, 0, 1, 0, 2)); // stall
        tbl.push_back(mk(1, 17, 16, 3, 18, 1, 0, 0, 0, 0, 2, 2)); // x16 in WB slot -> 0
        tbl.push_back(mk(1, 18,  1, 3, 20, 1, 1, 0, 0, 0, 1, 2)); // lw x20,(x18)
        tbl.push_back(mk(1, 20,  1, 3, 21, 1, 0, 0, 1, 0, 0, 2)); // flush beats stall
        tbl.push_back(mk(1, 20,  1, 3, 21, 1, 0, 0, 0, 0, 0, 2)); // load was flushed
        tbl.push_back(mk(1, 21,  0, 1, 22, 1, 1, 0, 0, 0, 1, 2)); // lw x22,(x21)
        tbl.push_back(mk(1, 22,  0, 1, 23, 1, 0, 1, 1, 0, 1, 2)); // hold beats flush
        tbl.push_back(mk(1, 22,  0, 1, 23, 1, 0, 0, 0, 1, 0, 3)); // load survived
        tbl.push_back(mk(1, 22,  0, 1, 23, 1, 0, 0, 0, 0, 2, 3));

        // DEPTH=5, LOAD_LAT=3, CNTW=2
        tbl2.push_back(mk(1,  1,  0, 1,  9, 1, 1, 0, 0, 0, 0, 0)); // lw x9
        tbl2.push_back(mk(1,  9,  0, 3, 10, 1, 0, 0, 0, 1, 0, 1));
        tbl2.push_back(mk(1,  9,  0, 3, 10, 1, 0, 0, 0, 1, 0, 2));
        tbl2.push_back(mk(1,  9,  0, 3, 10, 1, 0, 0, 0, 0, 3, 2));
        tbl2.push_back(mk(1,  1,  0, 1,  9, 1, 1, 0, 0, 0, 0, 2)); // lw x9
        tbl2.push_back(mk(1,  9,  0, 3, 10, 1, 0, 0, 0, 1, 0, 3));
        tbl2.push_back(mk(1,  9,  0, 3, 10, 1, 0, 0, 0, 1, 0, 3)); // saturated
        tbl2.push_back(mk(1,  9,  0, 3, 10, 1, 0, 0, 0, 0, 3, 3));

        drive(idle, 0);
        drive(idle, 1);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_sel", 32'(fwd_sel), 0);
        chk("rst_cnt", 32'(stall_cnt), 0);
        chk("rst_sel2", 32'(b_fwd_sel), 0);
        chk("rst_cnt2", 32'(b_stall_cnt), 0);
        rstn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], 0, $sformatf("v%0d", i));
        end

        // reset in the middle of a load-use stall
        drive(mk(1, 1, 0, 1, 5, 1, 1, 0, 0, 0, 0, 0), 0);
        @(posedge clk);
        #1;
        drive(mk(1, 5, 0, 1, 6, 1, 0, 0, 0, 0, 0, 0), 0);
        #3;
        chk("mid_stall", 32'(stall), 1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(stall), 0);
        chk("mid_rst_sel", 32'(fwd_sel), 0);
        chk("mid_rst_cnt", 32'(stall_cnt), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        #3;
        chk("post_rst_stall", 32'(stall), 0);
        @(posedge clk);
        #1;
        chk("post_rst_sel", 32'(fwd_sel), 0);
        chk("post_rst_cnt", 32'(stall_cnt), 0);
        drive(idle, 0);

        for (int i = 0; i < tbl2.size(); i++) begin
            run_vec(tbl2[i], 1, $sformatf("p%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
